// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and defaults for the 8-bit core front end
package cpu_pkg;

    localparam int ADDRESS_WIDTH = 8;
    localparam int DATA_WIDTH    = 8;
    localparam logic [ADDRESS_WIDTH-1:0] RESET_ADDRESS = 8'h00;

    typedef enum logic {
        FETCH_RUN,
        FETCH_HALTED
    } fetch_state_t;

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0]    data;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - small synchronous FIFO of fetched {pc, data} entries
// Flush wins over push; a push is accepted when full only if the head is popped on the same edge.
module fetch_buffer
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         i_push,
    input  fetch_entry_t i_entry,
    input  logic         i_pop,
    input  logic         i_flush,
    output logic         o_full,
    output logic         o_empty,
    output fetch_entry_t o_head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    fetch_entry_t      r_mem [DEPTH];
    logic [PW-1:0]     r_rd_ptr;
    logic [PW-1:0]     r_wr_ptr;
    logic [CW-1:0]     r_count;
    logic              w_do_pop;
    logic              w_do_push;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == FULL_COUNT);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = r_mem[r_rd_ptr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_entry;
                r_wr_ptr        <= next_ptr(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - PC sequencing, prefetch capture, branch flush and sticky halt
// Owns the program counter driving instruction_mem and feeds decode through fetch_buffer.
module fetch_controller #(
    parameter int ADDRESS_WIDTH = cpu_pkg::ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = cpu_pkg::DATA_WIDTH,
    parameter int BUFFER_DEPTH  = 2,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_ADDRESS = cpu_pkg::RESET_ADDRESS
) (
    input  logic                     clock,
    input  logic                     reset_n,
    output logic [ADDRESS_WIDTH-1:0] instruction_address,
    input  logic [DATA_WIDTH-1:0]    instruction_data,
    output logic [DATA_WIDTH-1:0]    fetch_data,
    output logic [ADDRESS_WIDTH-1:0] fetch_pc,
    output logic                     fetch_valid,
    input  logic                     fetch_ready,
    input  logic                     branch_valid,
    input  logic [ADDRESS_WIDTH-1:0] branch_target,
    input  logic                     halt,
    output logic                     halted
);

    cpu_pkg::fetch_state_t    r_state;
    logic [ADDRESS_WIDTH-1:0] r_pc;
    cpu_pkg::fetch_entry_t    w_entry;
    cpu_pkg::fetch_entry_t    w_head;
    logic                     w_full;
    logic                     w_empty;
    logic                     w_pop;
    logic                     w_can_capture;
    logic                     w_push;

    assign w_pop         = fetch_valid && fetch_ready;
    assign w_can_capture = !w_full || w_pop;
    // A capture needs RUN, no redirect and no halt request on this very edge.
    assign w_push        = !branch_valid && (r_state == cpu_pkg::FETCH_RUN) && !halt && w_can_capture;
    assign w_entry       = '{pc: r_pc, data: instruction_data};

    assign instruction_address = r_pc;
    assign fetch_valid         = !w_empty;
    assign fetch_data          = w_head.data;
    assign fetch_pc            = w_head.pc;
    assign halted              = (r_state == cpu_pkg::FETCH_HALTED);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= cpu_pkg::FETCH_RUN;
            r_pc    <= RESET_ADDRESS;
        end else if (branch_valid) begin
            r_pc    <= branch_target;
            r_state <= halt ? cpu_pkg::FETCH_HALTED : cpu_pkg::FETCH_RUN;
        end else begin
            case (r_state)
                cpu_pkg::FETCH_RUN: begin
                    if (halt) begin
                        r_state <= cpu_pkg::FETCH_HALTED;
                    end else if (w_can_capture) begin
                        r_pc <= r_pc + 1'b1;
                    end
                end
                cpu_pkg::FETCH_HALTED: begin
                    r_state <= cpu_pkg::FETCH_HALTED;
                end
            endcase
        end
    end

    fetch_buffer #(
        .DEPTH (BUFFER_DEPTH)
    ) u_fetch_buffer (
        .clock   (clock),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_entry (w_entry),
        .i_pop   (w_pop),
        .i_flush (branch_valid),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - directed vector bench for fetch_controller
module tb_fetch_controller;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] instruction_address;
    logic [7:0] instruction_data;
    logic [7:0] fetch_data;
    logic [7:0] fetch_pc;
    logic       fetch_valid;
    logic       fetch_ready;
    logic       branch_valid;
    logic [7:0] branch_target;
    logic       halt;
    logic       halted;

    logic [7:0] mem [256];
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rdy;
        logic       br;
        logic [7:0] tgt;
        logic       hlt;
        logic       v;
        logic [7:0] pc;
        logic [7:0] addr;
        logic       hd;
    } vec_t;

    vec_t vt[$];

    always #5 clock = ~clock;

    assign instruction_data = mem[instruction_address];

    fetch_controller dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .instruction_address (instruction_address),
        .instruction_data    (instruction_data),
        .fetch_data          (fetch_data),
        .fetch_pc            (fetch_pc),
        .fetch_valid         (fetch_valid),
        .fetch_ready         (fetch_ready),
        .branch_valid        (branch_valid),
        .branch_target       (branch_target),
        .halt                (halt),
        .halted              (halted)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    function automatic void add(input logic rdy, input logic br, input logic [7:0] tgt, input logic hlt,
                                input logic v, input logic [7:0] pc, input logic [7:0] addr, input logic hd);
        vec_t e;
        e = '{rdy: rdy, br: br, tgt: tgt, hlt: hlt, v: v, pc: pc, addr: addr, hd: hd};
        vt.push_back(e);
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'(i);
        end

        //   rdy br  tgt    hlt v  pc     addr   halted
        add(1, 0, 8'h00, 0, 1, 8'h00, 8'h01, 0);   // first capture after reset
        add(1, 0, 8'h00, 0, 1, 8'h01, 8'h02, 0);
        add(1, 0, 8'h00, 0, 1, 8'h02, 8'h03, 0);
        add(1, 0, 8'h00, 0, 1, 8'h03, 8'h04, 0);
        add(0, 0, 8'h00, 0, 1, 8'h03, 8'h05, 0);   // backpressure: fill
        add(0, 0, 8'h00, 0, 1, 8'h03, 8'h05, 0);   // full: stall
        add(0, 0, 8'h00, 0, 1, 8'h03, 8'h05, 0);
        add(0, 0, 8'h00, 0, 1, 8'h03, 8'h05, 0);
        add(0, 0, 8'h00, 0, 1, 8'h03, 8'h05, 0);
        add(1, 0, 8'h00, 0, 1, 8'h04, 8'h06, 0);   // release: pop while full
        add(1, 0, 8'h00, 0, 1, 8'h05, 8'h07, 0);
        add(1, 0, 8'h00, 0, 1, 8'h06, 8'h08, 0);
        add(0, 1, 8'h40, 0, 0, 8'h00, 8'h40, 0);   // branch with 2 buffered
        add(1, 0, 8'h00, 0, 1, 8'h40, 8'h41, 0);
        add(1, 0, 8'h00, 0, 1, 8'h41, 8'h42, 0);
        add(1, 1, 8'hFE, 0, 0, 8'h00, 8'hFE, 0);   // branch with pop same edge
        add(1, 0, 8'h00, 0, 1, 8'hFE, 8'hFF, 0);
        add(1, 0, 8'h00, 0, 1, 8'hFF, 8'h00, 0);   // wrap
        add(1, 0, 8'h00, 0, 1, 8'h00, 8'h01, 0);
        add(1, 0, 8'h00, 0, 1, 8'h01, 8'h02, 0);
        add(0, 0, 8'h00, 0, 1, 8'h01, 8'h03, 0);
        add(0, 0, 8'h00, 1, 1, 8'h01, 8'h03, 1);   // halt pulse
        add(1, 0, 8'h00, 0, 1, 8'h02, 8'h03, 1);   // drains, stays halted
        add(1, 0, 8'h00, 0, 0, 8'h00, 8'h03, 1);
        add(1, 0, 8'h00, 0, 0, 8'h00, 8'h03, 1);
        add(1, 1, 8'h10, 0, 0, 8'h00, 8'h10, 0);   // resume by branch
        add(1, 0, 8'h00, 0, 1, 8'h10, 8'h11, 0);
        add(1, 1, 8'h20, 1, 0, 8'h00, 8'h20, 1);   // branch with halt
        add(1, 0, 8'h00, 0, 0, 8'h00, 8'h20, 1);
        add(1, 1, 8'h30, 0, 0, 8'h00, 8'h30, 0);
        add(1, 0, 8'h00, 0, 1, 8'h30, 8'h31, 0);
        add(0, 0, 8'h00, 0, 1, 8'h30, 8'h32, 0);
        add(0, 0, 8'h00, 0, 1, 8'h30, 8'h32, 0);   // full buffer for reset test

        reset_n       = 1'b0;
        fetch_ready   = 1'b1;
        branch_valid  = 1'b0;
        branch_target = 8'h00;
        halt          = 1'b0;
        #1;
        check("reset_addr", instruction_address, 8'h00);
        check("reset_valid", {7'd0, fetch_valid}, 8'h00);
        check("reset_halted", {7'd0, halted}, 8'h00);
        check("reset_data", fetch_data, 8'h00);
        check("reset_pc", fetch_pc, 8'h00);
        @(posedge clock);
        #1;
        check("reset_hold_valid", {7'd0, fetch_valid}, 8'h00);
        check("reset_hold_addr", instruction_address, 8'h00);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < vt.size(); i++) begin
            fetch_ready   = vt[i].rdy;
            branch_valid  = vt[i].br;
            branch_target = vt[i].tgt;
            halt          = vt[i].hlt;
            @(posedge clock);
            #1;
            check($sformatf("v%0d valid", i), {7'd0, fetch_valid}, {7'd0, vt[i].v});
            check($sformatf("v%0d addr", i), instruction_address, vt[i].addr);
            check($sformatf("v%0d halted", i), {7'd0, halted}, {7'd0, vt[i].hd});
            if (vt[i].v) begin
                check($sformatf("v%0d fetch_pc", i), fetch_pc, vt[i].pc);
                check($sformatf("v%0d fetch_data", i), fetch_data, mem[vt[i].pc]);
            end
        end

        // Asynchronous reset mid-cycle with a full, stalled buffer.
        branch_valid = 1'b0;
        halt         = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_valid", {7'd0, fetch_valid}, 8'h00);
        check("async_reset_addr", instruction_address, 8'h00);
        check("async_reset_halted", {7'd0, halted}, 8'h00);
        check("async_reset_pc", fetch_pc, 8'h00);
        @(posedge clock);
        #1;
        check("async_reset_hold_valid", {7'd0, fetch_valid}, 8'h00);
        @(negedge clock);
        reset_n     = 1'b1;
        fetch_ready = 1'b1;
        @(posedge clock);
        #1;
        check("restart_valid", {7'd0, fetch_valid}, 8'h01);
        check("restart_pc", fetch_pc, 8'h00);
        check("restart_addr", instruction_address, 8'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
